// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP clause scanner slice.
package bcp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT,
    ST_DONE
  } state_e;

  localparam int DEF_VAR_NUM    = 8;
  localparam int DEF_CLAUSE_NUM = 16;

  // Clause word layout: type bits in the low half, presence mask in the high half.
  localparam int TYPE_LSB = 0;

  function automatic int mask_lsb(input int var_num);
    return var_num;
  endfunction

endpackage

// File: rtl/bcp_clause_scanner_if.sv
// Implication stream from the clause scanner toward the implication queue.
interface bcp_clause_scanner_if
  import bcp_pkg::*;
#(
  parameter int VAR_NUM    = DEF_VAR_NUM,
  parameter int CLAUSE_NUM = DEF_CLAUSE_NUM
);
  localparam int IDX_W = $clog2(CLAUSE_NUM);
  localparam int VAR_W = $clog2(VAR_NUM);

  logic             imp_valid;
  logic             imp_ready;
  logic [VAR_W-1:0] imp_var;
  logic             imp_value;
  logic [IDX_W-1:0] imp_clause;

  modport master (output imp_valid, imp_var, imp_value, imp_clause, input imp_ready);
  modport slave  (input imp_valid, imp_var, imp_value, imp_clause, output imp_ready);
endinterface

// File: rtl/bcp_clause_eval.sv
// Combinational status of one clause against an assignment snapshot.
module bcp_clause_eval #(
  parameter int VAR_NUM = 8,
  parameter int VAR_W   = $clog2(VAR_NUM)
) (
  input  logic [VAR_NUM-1:0] mask,
  input  logic [VAR_NUM-1:0] lit_type,
  input  logic [VAR_NUM-1:0] assignment,
  input  logic [VAR_NUM-1:0] free,
  output logic               sat,
  output logic               unit,
  output logic               conflict,
  output logic [VAR_W-1:0]   free_var
);
  logic [VAR_NUM-1:0] true_lits;
  logic [VAR_NUM-1:0] free_lits;

  always_comb begin
    true_lits = mask & ~free & ~(assignment ^ lit_type);
    free_lits = mask & free;
    sat       = |true_lits;
    unit      = !sat && ($countones(free_lits) == 1);
    conflict  = !sat && (free_lits == '0);
    // Only meaningful for a unit clause, where exactly one bit is set.
    free_var  = '0;
    for (int unsigned i = 0; i < VAR_NUM; i++) begin
      if (free_lits[i]) free_var = VAR_W'(i);
    end
  end
endmodule

// File: rtl/bcp_clause_scanner.sv
// Clause store plus scan FSM emitting unit implications and stopping on conflict.
module bcp_clause_scanner
  import bcp_pkg::*;
#(
  parameter int VAR_NUM    = DEF_VAR_NUM,
  parameter int CLAUSE_NUM = DEF_CLAUSE_NUM,
  parameter int IDX_W      = $clog2(CLAUSE_NUM),
  parameter int VAR_W      = $clog2(VAR_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_addr,
  input  logic [2*VAR_NUM-1:0] load_clause,
  input  logic [IDX_W:0]       num_clauses,
  input  logic [VAR_NUM-1:0]   assignment,
  input  logic [VAR_NUM-1:0]   free,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 conflict,
  output logic [IDX_W-1:0]     conflict_idx,
  bcp_clause_scanner_if.master imp
);
  localparam int             MASK_LSB = mask_lsb(VAR_NUM);
  localparam logic [IDX_W:0] MAX_NUM  = (IDX_W+1)'(CLAUSE_NUM);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W:0]       num_q, num_d;
  logic [VAR_NUM-1:0]   asg_q, asg_d, free_q, free_d;
  logic                 conflict_q, conflict_d;
  logic [IDX_W-1:0]     cidx_q, cidx_d;
  logic [VAR_W-1:0]     imp_var_q, imp_var_d;
  logic                 imp_value_q, imp_value_d;
  logic [IDX_W-1:0]     imp_clause_q, imp_clause_d;
  logic [2*VAR_NUM-1:0] store_q [CLAUSE_NUM];

  logic [2*VAR_NUM-1:0] cur_clause;
  logic [VAR_NUM-1:0]   cur_mask, cur_type;
  logic [IDX_W:0]       num_clamped;
  logic                 last_idx;
  logic                 ev_sat, ev_unit, ev_conflict;
  logic [VAR_W-1:0]     ev_free_var;

  assign cur_clause  = store_q[idx_q];
  assign cur_mask    = cur_clause[MASK_LSB +: VAR_NUM];
  assign cur_type    = cur_clause[TYPE_LSB +: VAR_NUM];
  assign num_clamped = (num_clauses > MAX_NUM) ? MAX_NUM : num_clauses;
  assign last_idx    = ({1'b0, idx_q} == (num_q - 1'b1));

  bcp_clause_eval #(
    .VAR_NUM (VAR_NUM),
    .VAR_W   (VAR_W)
  ) u_eval (
    .mask       (cur_mask),
    .lit_type   (cur_type),
    .assignment (asg_q),
    .free       (free_q),
    .sat        (ev_sat),
    .unit       (ev_unit),
    .conflict   (ev_conflict),
    .free_var   (ev_free_var)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    num_d        = num_q;
    asg_d        = asg_q;
    free_d       = free_q;
    conflict_d   = conflict_q;
    cidx_d       = cidx_q;
    imp_var_d    = imp_var_q;
    imp_value_d  = imp_value_q;
    imp_clause_d = imp_clause_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          asg_d      = assignment;
          free_d     = free;
          num_d      = num_clamped;
          conflict_d = 1'b0;
          cidx_d     = '0;
          idx_d      = '0;
          state_d    = (num_clamped == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (ev_conflict) begin
          conflict_d = 1'b1;
          cidx_d     = idx_q;
          state_d    = ST_DONE;
        end else if (ev_unit) begin
          imp_var_d    = ev_free_var;
          imp_value_d  = cur_type[ev_free_var];
          imp_clause_d = idx_q;
          state_d      = ST_EMIT;
        end else if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (imp.imp_ready) begin
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      num_q        <= '0;
      asg_q        <= '0;
      free_q       <= '0;
      conflict_q   <= 1'b0;
      cidx_q       <= '0;
      imp_var_q    <= '0;
      imp_value_q  <= 1'b0;
      imp_clause_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      asg_q        <= asg_d;
      free_q       <= free_d;
      conflict_q   <= conflict_d;
      cidx_q       <= cidx_d;
      imp_var_q    <= imp_var_d;
      imp_value_q  <= imp_value_d;
      imp_clause_q <= imp_clause_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CLAUSE_NUM; i++) store_q[i] <= '0;
    end else if (load_en && (state_q == ST_IDLE)) begin
      store_q[load_addr] <= load_clause;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign conflict       = conflict_q;
  assign conflict_idx   = cidx_q;
  assign imp.imp_valid  = (state_q == ST_EMIT);
  assign imp.imp_var    = imp_var_q;
  assign imp.imp_value  = imp_value_q;
  assign imp.imp_clause = imp_clause_q;
endmodule

// File: tb/tb_bcp_clause_scanner.sv
// Directed bench for bcp_clause_scanner with a clause-level reference model.
module tb_bcp_clause_scanner;
  localparam int VN = 8;
  localparam int CN = 16;

  typedef struct {int v; int val; int c;} imp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [15:0] load_clause = '0;
  logic [4:0]  num_clauses = '0;
  logic [7:0]  assignment = '0;
  logic [7:0]  free = '0;
  logic        start = 1'b0;
  logic        busy, done, conflict;
  logic [3:0]  conflict_idx;

  bcp_clause_scanner_if #(.VAR_NUM(VN), .CLAUSE_NUM(CN)) imp_if ();

  bcp_clause_scanner #(.VAR_NUM(VN), .CLAUSE_NUM(CN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_clause  (load_clause),
    .num_clauses  (num_clauses),
    .assignment   (assignment),
    .free         (free),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .conflict     (conflict),
    .conflict_idx (conflict_idx),
    .imp          (imp_if)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] m_mask [CN];
  logic [7:0] m_type [CN];
  imp_t exp_q[$];
  int   exp_conf, exp_cidx, exp_lat, last_lat;
  int   stall_left = 0;
  bit   scan_active = 0;
  bit   rec_first = 0;
  int   f_var, f_val, f_cls;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One consumer cycle: ready is withheld for stall_left valid cycles, then held high.
  task automatic tick();
    @(posedge clk);
    #1;
    if (imp_if.imp_valid && stall_left > 0) begin
      stall_left--;
      imp_if.imp_ready = 1'b0;
    end else begin
      imp_if.imp_ready = (stall_left == 0);
    end
  endtask

  task automatic model(input int num, input logic [7:0] a, input logic [7:0] f, input int stall);
    int n, scanned, units, nf, fv;
    bit sat;
    exp_q.delete();
    exp_conf = 0; exp_cidx = 0;
    n = (num > CN) ? CN : num;
    scanned = 0; units = 0;
    for (int c = 0; c < n; c++) begin
      scanned++;
      sat = 0; nf = 0; fv = 0;
      for (int v = 0; v < VN; v++) begin
        if (m_mask[c][v]) begin
          if (f[v]) begin nf++; fv = v; end
          else if (a[v] == m_type[c][v]) sat = 1;
        end
      end
      if (!sat && nf == 0) begin exp_conf = 1; exp_cidx = c; break; end
      if (!sat && nf == 1) begin
        exp_q.push_back('{fv, int'(m_type[c][fv]), c});
        units++;
      end
    end
    exp_lat = (n == 0) ? 1 : scanned + 1 + units + ((units > 0) ? stall : 0);
  endtask

  task automatic load(input int a, input logic [15:0] w);
    load_addr = 4'(a); load_clause = w; load_en = 1'b1;
    tick();
    load_en = 1'b0;
    m_mask[a] = w[15:8];
    m_type[a] = w[7:0];
  endtask

  task automatic run_scan(input int num, input logic [7:0] a, input logic [7:0] f,
                          input int stall, input bit disturb);
    int lat;
    model(num, a, f, stall);
    stall_left = stall;
    imp_if.imp_ready = (stall == 0);
    num_clauses = 5'(num); assignment = a; free = f; start = 1'b1;
    scan_active = 1;
    tick();
    start = 1'b0;
    if (disturb) begin
      // Everything driven here lands while busy and must leave the scan untouched.
      assignment = ~a; free = ~f; start = 1'b1;
      load_en = 1'b1; load_addr = 4'd4; load_clause = 16'hFFFF;
    end
    lat = 1;
    while (!done && lat < 300) begin
      tick();
      start = 1'b0; load_en = 1'b0;
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
    else chk("latency", lat, exp_lat);
    last_lat = lat;
    tick();
    scan_active = 0;
    chk("conflict_sticky", conflict, exp_conf);
    chk("busy_after_done", busy, 0);
    tick();
    chk("no_redone", done, 0);
  endtask

  initial begin
    imp_if.imp_ready = 1'b1;
    for (int i = 0; i < CN; i++) begin m_mask[i] = '0; m_type[i] = '0; end

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (imp_if.imp_valid) begin
            if (exp_q.size() == 0) chk("spurious_imp", 1, 0);
            else begin
              chk("imp", {imp_if.imp_var, imp_if.imp_value, imp_if.imp_clause},
                  (exp_q[0].v << 5) | (exp_q[0].val << 4) | exp_q[0].c);
              if (rec_first) begin
                f_var = imp_if.imp_var; f_val = imp_if.imp_value; f_cls = imp_if.imp_clause;
                rec_first = 0;
              end
              if (imp_if.imp_ready) void'(exp_q.pop_front());
            end
          end
          if (done) begin
            if (!scan_active) chk("spurious_done", 1, 0);
            else begin
              chk("conflict", conflict, exp_conf);
              if (exp_conf != 0) chk("conflict_idx", conflict_idx, exp_cidx);
              chk("imps_left", exp_q.size(), 0);
            end
          end else if (busy) begin
            chk("conflict_cleared", conflict, 0);
          end
        end
      end
    join_none

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", imp_if.imp_valid, 0);
    chk("rst_conflict", conflict, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single satisfied clause.
    load(0, 16'h0303);
    run_scan(1, 8'h01, 8'hFE, 0, 0);
    chk("t1_lat", last_lat, 2);

    // Unit clause with a stalled consumer.
    load(0, 16'h0505);
    rec_first = 1;
    run_scan(1, 8'h00, 8'h04, 3, 0);
    chk("t2_var", f_var, 2);
    chk("t2_val", f_val, 1);
    chk("t2_cls", f_cls, 0);
    chk("t2_lat", last_lat, 6);

    // Conflict at clause 1 stops the scan before clause 2.
    load(0, 16'h0303);
    load(1, 16'h0300);
    load(2, 16'h0101);
    run_scan(3, 8'h03, 8'h00, 0, 0);
    chk("t3_cidx", conflict_idx, 1);
    chk("t3_lat", last_lat, 3);

    run_scan(0, 8'h00, 8'h00, 0, 0);
    chk("t4_lat", last_lat, 1);

    // Empty-mask clause conflicts.
    load(1, 16'h8080);
    run_scan(4, 8'h83, 8'h00, 0, 0);
    chk("t5_cidx", conflict_idx, 3);

    // Two units; mid-scan input changes, start and load while busy.
    load(0, 16'h0C04);
    load(1, 16'h3000);
    load(2, 16'hC040);
    load(3, 16'h2121);
    run_scan(4, 8'h00, 8'h28, 0, 1);
    run_scan(5, 8'h00, 8'h28, 2, 0);
    chk("t7_cidx", conflict_idx, 4);

    // Oversized count is clamped to the store depth.
    for (int i = 0; i < CN; i++) load(i, 16'h0101);
    run_scan(31, 8'h01, 8'h00, 0, 0);
    chk("t8_lat", last_lat, 17);

    // Reset while an implication is pending.
    load(0, 16'h0505);
    model(1, 8'h00, 8'h04, 0);
    stall_left = 1000;
    imp_if.imp_ready = 1'b0;
    num_clauses = 5'd1; assignment = 8'h00; free = 8'h04; start = 1'b1;
    scan_active = 1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && !imp_if.imp_valid; k++) tick();
    chk("t9_valid_seen", imp_if.imp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t9_valid_drop", imp_if.imp_valid, 0);
    chk("t9_busy_drop", busy, 0);
    chk("t9_done_low", done, 0);
    exp_q.delete();
    scan_active = 0;
    stall_left = 0;
    imp_if.imp_ready = 1'b1;
    for (int i = 0; i < CN; i++) begin m_mask[i] = '0; m_type[i] = '0; end
    tick();
    rst_n = 1'b1;
    tick();
    run_scan(1, 8'h00, 8'h04, 0, 0);
    chk("t9_cidx", conflict_idx, 0);
    chk("t9_conf", conflict, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bcp_clause_scanner.md
Name: bcp_clause_scanner

Overview:
Upstream sequencer for the BCP unit-clause check. It holds a small clause store and, on start, walks the clauses in index order one per cycle against a snapshot of the current assignment. For each clause it detects satisfied, unit or conflict status. Each implied literal is emitted on a valid/ready interface toward the implication queue, and scanning stops at the first conflict.

Parameters:
VAR_NUM, 8, number of variables and literal slots per clause
CLAUSE_NUM, 16, clause store depth
IDX_W, $clog2(CLAUSE_NUM), clause index width
VAR_W, $clog2(VAR_NUM), variable index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_en  in  1  write load_clause into store at load_addr; ignored while busy
load_addr  in  IDX_W  store write index
load_clause  in  2*VAR_NUM  [2*VAR_NUM-1:VAR_NUM] mask (var present), [VAR_NUM-1:0] type (1 = positive literal)
num_clauses  in  IDX_W+1  number of clauses to scan (0..CLAUSE_NUM), sampled at start
assignment  in  VAR_NUM  variable values, sampled at start
free  in  VAR_NUM  1 = variable unassigned, sampled at start
start  in  1  begin scan; honoured only in IDLE
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of scan
conflict  out  1  sticky until next accepted start
conflict_idx  out  IDX_W  clause index that conflicted
imp_valid  out  1  implication available
imp_ready  in  1  consumer accepts implication
imp_var  out  VAR_W  implied variable index
imp_value  out  1  implied value (= type bit of that literal)
imp_clause  out  IDX_W  source clause index

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; clause store cleared to all zeros; index and snapshot registers 0.
- Literal i is false when mask[i] & ~free[i] & (assignment[i] != type[i]). It is true when mask[i] & ~free[i] & (assignment[i] == type[i]).
- A clause is sat if any literal is true. It is unit if not sat and popcount(mask & free) == 1. It is conflict if not sat and (mask & free) == 0. A mask of 0 in range is therefore a conflict.
- IDLE:
  - start=1 latches assignment, free and num_clauses; clears conflict and conflict_idx; idx <= 0.
  - If num_clauses == 0, go to DONE; otherwise go to SCAN.
- SCAN (one clause per cycle, clause[idx] evaluated combinationally from the registered snapshot):
  - conflict: conflict <= 1, conflict_idx <= idx, go to DONE. Remaining clauses are not scanned.
  - unit: imp_var <= index of the single free masked bit; imp_value <= type at that bit; imp_clause <= idx; go to EMIT.
  - sat/other: if idx == num_clauses-1 go to DONE, else idx+1.
- EMIT:
  - imp_valid=1; imp_var, imp_value and imp_clause are held stable until imp_valid & imp_ready.
  - On handshake: imp_valid falls next cycle. Go to DONE if idx was the last clause; otherwise idx+1 and return to SCAN.
  - imp_ready while imp_valid=0 has no effect.
- DONE: done=1 for exactly one cycle, then IDLE. conflict remains visible after done.
- Latency:
  - N clauses with no unit/conflict: done asserts in cycle N+1 after the start edge.
  - Each unit clause adds 1 cycle plus the ready stall.
- The snapshot is not updated during a scan; implications emitted are not fed back into the scan.
- Boundaries:
  - load_en while busy is dropped (store unchanged).
  - start while busy is ignored.
  - num_clauses > CLAUSE_NUM is clamped to CLAUSE_NUM.
  - Index wrap is impossible because the scan terminates at num_clauses-1.
- Reset mid-operation: any state returns to IDLE immediately; imp_valid and done drop; the store is cleared.

Decomposition:
- Package bcp_pkg:
  - state enum {IDLE, SCAN, EMIT, DONE}
  - mask/type field offset constants for the clause word
  - width helper constants
- Sub-module bcp_clause_eval (purely combinational):
  - inputs: mask, type, assignment, free
  - outputs: sat, unit, conflict, free_var
- The scanner holds the store, snapshot, FSM and output registers.

Test Plan:
- Reset, then load clause 0 = {mask 0x03, type 0x03}; assignment 0x01, free 0xFE, num_clauses 1, start -> no imp_valid, done pulses 2 cycles after start, conflict=0.
- Clause 0 = {0x05, 0x05}; assignment 0x00, free 0x04; start with imp_ready held 0 for 3 cycles -> imp_valid=1, imp_var=2, imp_value=1, imp_clause=0, all stable until the ready cycle; done follows.
- Clauses {0x03,0x03} (sat), {0x03,0x00}; assignment 0x03, free 0x00, num 3 -> conflict=1, conflict_idx=1, clause 2 never scanned, done pulses, conflict stays 1 until next start.
- num_clauses 0 -> done on cycle after start. A clause with mask 0x00 -> conflict.
- Change assignment mid-scan -> results match the start snapshot. Pulse start while busy -> ignored. Pulse load_en while busy -> store unchanged (read back via a later scan).
- Assert rst_n=0 during EMIT -> imp_valid and busy drop asynchronously; a rescan of a previously loaded index reports a conflict (store cleared).
